pulse_compression_controller: RTL and testbench

- Top-level sequencer for the matched-filter pulse compression chain.
- Starts the coefficient MIF reader and frames its output stream into the FIR coefficient load port, then does the same for the input-data MIF reader into the FIR sample port.
- Holds the filter enabled while its pipeline drains, then signals completion.
- Checks each reader's finished flag against its own counters and flags any mismatch as an error.

---
 rtl/pulse_compression_controller_if.sv | 31 +++
 rtl/pulse_compression_controller.sv | 218 +++++++++++++++++++++
 tb/tb_pulse_compression_controller.sv | 185 ++++++++++++++++++
 3 files changed

// File: rtl/pulse_compression_controller_if.sv
// Control and reader-handshake bundle for the pulse compression sequencer.
// The slave modport is the sequencer side; master is the host/reader side.
interface pulse_compression_controller_if #(
  parameter int unsigned CNT_WIDTH = 20
);
  logic                 start;
  logic                 abort;
  logic                 coeffFinishedFlag;
  logic                 dataFinishedFlag;
  logic                 coeffEnable;
  logic                 dataEnable;
  logic                 coeffValid;
  logic                 dataValid;
  logic [CNT_WIDTH-1:0] dataIndex;
  logic                 filterEnable;
  logic                 busy;
  logic                 done;
  logic                 error;

  modport slave (
    input  start, abort, coeffFinishedFlag, dataFinishedFlag,
    output coeffEnable, dataEnable, coeffValid, dataValid, dataIndex,
           filterEnable, busy, done, error
  );

  modport master (
    output start, abort, coeffFinishedFlag, dataFinishedFlag,
    input  coeffEnable, dataEnable, coeffValid, dataValid, dataIndex,
           filterEnable, busy, done, error
  );
endinterface

// File: rtl/pulse_compression_controller.sv
// Sequencer for the matched-filter chain: loads FIR coefficients, streams samples,
// drains the pipeline, and cross-checks each reader's finished flag against its word count.
module pulse_compression_controller #(
  parameter int unsigned COEFF_LENGTH   = 800,
  parameter int unsigned DATA_LENGTH    = 1600,
  parameter int unsigned FILTER_LATENCY = 16,
  parameter int unsigned FLAG_TIMEOUT   = 4,
  parameter int unsigned CNT_WIDTH      = 20
) (
  input logic                           clock,
  input logic                           resetN,
  pulse_compression_controller_if.slave bus
);

  typedef enum logic [3:0] {
    S_IDLE,
    S_COEFF_PRIME,
    S_LOAD_COEFF,
    S_CHECK_COEFF,
    S_DATA_PRIME,
    S_STREAM_DATA,
    S_CHECK_DATA,
    S_DRAIN,
    S_DONE,
    S_ERROR
  } state_t;

  localparam logic [CNT_WIDTH-1:0] PRIME_LAST   = CNT_WIDTH'(1);
  localparam logic [CNT_WIDTH-1:0] COEFF_LAST   = CNT_WIDTH'(COEFF_LENGTH - 1);
  localparam logic [CNT_WIDTH-1:0] DATA_LAST    = CNT_WIDTH'(DATA_LENGTH - 1);
  localparam logic [CNT_WIDTH-1:0] DRAIN_LAST   = CNT_WIDTH'(FILTER_LATENCY - 1);
  localparam logic [CNT_WIDTH-1:0] TIMEOUT_LAST = CNT_WIDTH'(FLAG_TIMEOUT - 1);

  state_t               state_q, state_d;
  logic [CNT_WIDTH-1:0] cnt_q, cnt_d;
  logic [CNT_WIDTH-1:0] data_index_q, data_index_d;
  logic                 coeff_en_q, coeff_en_d;
  logic                 data_en_q, data_en_d;
  logic                 coeff_valid_q, coeff_valid_d;
  logic                 data_valid_q, data_valid_d;
  logic                 filter_en_q, filter_en_d;
  logic                 busy_q, busy_d;
  logic                 done_q, done_d;
  logic                 error_q, error_d;
  logic                 to_error;

  // Outputs are computed for the state being entered so every one of them is a flop.
  always_comb begin
    state_d       = state_q;
    cnt_d         = cnt_q + CNT_WIDTH'(1);
    data_index_d  = '0;
    coeff_en_d    = coeff_en_q;
    data_en_d     = data_en_q;
    coeff_valid_d = 1'b0;
    data_valid_d  = 1'b0;
    filter_en_d   = filter_en_q;
    done_d        = 1'b0;
    error_d       = error_q;
    to_error      = 1'b0;

    case (state_q)
      S_IDLE: begin
        cnt_d = '0;
        if (bus.start && !bus.abort) begin
          if (bus.coeffFinishedFlag || bus.dataFinishedFlag) begin
            to_error = 1'b1;
          end else begin
            state_d    = S_COEFF_PRIME;
            coeff_en_d = 1'b1;
          end
        end
      end
      S_COEFF_PRIME: begin
        if (cnt_q == PRIME_LAST) begin
          state_d       = S_LOAD_COEFF;
          cnt_d         = '0;
          coeff_valid_d = 1'b1;
        end
      end
      S_LOAD_COEFF: begin
        coeff_valid_d = 1'b1;
        // The flag must rise only after the final word, so any sighting here is a count mismatch.
        if (bus.coeffFinishedFlag) begin
          to_error = 1'b1;
        end else if (cnt_q == COEFF_LAST) begin
          state_d       = S_CHECK_COEFF;
          cnt_d         = '0;
          coeff_valid_d = 1'b0;
        end
      end
      S_CHECK_COEFF: begin
        if (bus.coeffFinishedFlag) begin
          state_d     = S_DATA_PRIME;
          cnt_d       = '0;
          coeff_en_d  = 1'b0;
          data_en_d   = 1'b1;
          filter_en_d = 1'b1;
        end else if (cnt_q == TIMEOUT_LAST) begin
          to_error = 1'b1;
        end
      end
      S_DATA_PRIME: begin
        if (cnt_q == PRIME_LAST) begin
          state_d      = S_STREAM_DATA;
          cnt_d        = '0;
          data_valid_d = 1'b1;
        end
      end
      S_STREAM_DATA: begin
        data_valid_d = 1'b1;
        data_index_d = cnt_q + CNT_WIDTH'(1);
        if (bus.dataFinishedFlag) begin
          to_error = 1'b1;
        end else if (cnt_q == DATA_LAST) begin
          state_d      = S_CHECK_DATA;
          cnt_d        = '0;
          data_valid_d = 1'b0;
          data_index_d = '0;
        end
      end
      S_CHECK_DATA: begin
        if (bus.dataFinishedFlag) begin
          state_d   = S_DRAIN;
          cnt_d     = '0;
          data_en_d = 1'b0;
        end else if (cnt_q == TIMEOUT_LAST) begin
          to_error = 1'b1;
        end
      end
      S_DRAIN: begin
        if (cnt_q == DRAIN_LAST) begin
          state_d     = S_DONE;
          cnt_d       = '0;
          filter_en_d = 1'b0;
          done_d      = 1'b1;
        end
      end
      S_DONE: begin
        state_d = S_IDLE;
        cnt_d   = '0;
      end
      S_ERROR: begin
        cnt_d = '0;
      end
      default: begin
        state_d = S_IDLE;
        cnt_d   = '0;
      end
    endcase

    if (to_error) begin
      state_d       = S_ERROR;
      cnt_d         = '0;
      coeff_en_d    = 1'b0;
      data_en_d     = 1'b0;
      coeff_valid_d = 1'b0;
      data_valid_d  = 1'b0;
      data_index_d  = '0;
      filter_en_d   = 1'b0;
      error_d       = 1'b1;
    end

    // Abort overrides every transition above, including a fault detected in the same cycle.
    if (bus.abort && state_q != S_IDLE && state_q != S_ERROR) begin
      state_d       = S_IDLE;
      cnt_d         = '0;
      coeff_en_d    = 1'b0;
      data_en_d     = 1'b0;
      coeff_valid_d = 1'b0;
      data_valid_d  = 1'b0;
      data_index_d  = '0;
      filter_en_d   = 1'b0;
      done_d        = 1'b0;
      error_d       = error_q;
    end

    busy_d = (state_d != S_IDLE) && (state_d != S_ERROR);
  end

  always_ff @(posedge clock or negedge resetN) begin
    if (!resetN) begin
      state_q       <= S_IDLE;
      cnt_q         <= '0;
      data_index_q  <= '0;
      coeff_en_q    <= 1'b0;
      data_en_q     <= 1'b0;
      coeff_valid_q <= 1'b0;
      data_valid_q  <= 1'b0;
      filter_en_q   <= 1'b0;
      busy_q        <= 1'b0;
      done_q        <= 1'b0;
      error_q       <= 1'b0;
    end else begin
      state_q       <= state_d;
      cnt_q         <= cnt_d;
      data_index_q  <= data_index_d;
      coeff_en_q    <= coeff_en_d;
      data_en_q     <= data_en_d;
      coeff_valid_q <= coeff_valid_d;
      data_valid_q  <= data_valid_d;
      filter_en_q   <= filter_en_d;
      busy_q        <= busy_d;
      done_q        <= done_d;
      error_q       <= error_d;
    end
  end

  assign bus.coeffEnable  = coeff_en_q;
  assign bus.dataEnable   = data_en_q;
  assign bus.coeffValid   = coeff_valid_q;
  assign bus.dataValid    = data_valid_q;
  assign bus.dataIndex    = data_index_q;
  assign bus.filterEnable = filter_en_q;
  assign bus.busy         = busy_q;
  assign bus.done         = done_q;
  assign bus.error        = error_q;

endmodule

// File: tb/tb_pulse_compression_controller.sv
// Directed bench for pulse_compression_controller with COEFF_LENGTH=8, DATA_LENGTH=16,
// FILTER_LATENCY=4; reader flags are driven on a hand-timed cycle schedule.
module tb_pulse_compression_controller;
  localparam int unsigned CW = 20;

  logic clock  = 1'b0;
  logic resetN = 1'b0;

  pulse_compression_controller_if #(.CNT_WIDTH(CW)) bus ();

  pulse_compression_controller #(
    .COEFF_LENGTH  (8),
    .DATA_LENGTH   (16),
    .FILTER_LATENCY(4),
    .FLAG_TIMEOUT  (4),
    .CNT_WIDTH     (CW)
  ) dut (
    .clock (clock),
    .resetN(resetN),
    .bus   (bus)
  );

  always #5 clock = ~clock;

  int unsigned passed = 0;
  int unsigned total  = 0;

  // {coeffEnable, dataEnable, coeffValid, dataValid, filterEnable, busy, done, error}
  logic [7:0] obs;
  assign obs = {bus.coeffEnable, bus.dataEnable, bus.coeffValid, bus.dataValid,
                bus.filterEnable, bus.busy, bus.done, bus.error};

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    assert (got === exp) passed++;
    else $error("FAIL %s: got=%0h expected=%0h", tag, got, exp);
  endtask

  task automatic check_outs(input string tag, input logic [7:0] exp_vec, input logic [31:0] exp_idx);
    check({tag, " outs"}, {24'd0, obs}, {24'd0, exp_vec});
    check({tag, " idx"}, {{(32-CW){1'b0}}, bus.dataIndex}, exp_idx);
  endtask

  // Cycle k counts clock periods after the edge that sampled start (k=1 is first busy cycle).
  function automatic logic [7:0] nom_vec(input int k);
    if (k < 1)   return 8'b0000_0000;
    if (k <= 2)  return 8'b1000_0100;
    if (k <= 10) return 8'b1010_0100;
    if (k == 11) return 8'b1000_0100;
    if (k <= 13) return 8'b0100_1100;
    if (k <= 29) return 8'b0101_1100;
    if (k == 30) return 8'b0100_1100;
    if (k <= 34) return 8'b0000_1100;
    if (k == 35) return 8'b0000_0110;
    return 8'b0000_0000;
  endfunction

  function automatic logic [31:0] nom_idx(input int k);
    return (k >= 14 && k <= 29) ? 32'(k - 14) : 32'd0;
  endfunction

  task automatic launch();
    bus.start = 1'b1;
    @(negedge clock);
    bus.start = 1'b0;
  endtask

  task automatic run_nominal(input string tag, input int start_at);
    launch();
    for (int k = 1; k <= 37; k++) begin
      bus.coeffFinishedFlag = (k >= 11);
      bus.dataFinishedFlag  = (k >= 30);
      bus.start             = (k == start_at);
      check_outs($sformatf("%s k=%0d", tag, k), nom_vec(k), nom_idx(k));
      @(negedge clock);
    end
    bus.start             = 1'b0;
    bus.coeffFinishedFlag = 1'b0;
    bus.dataFinishedFlag  = 1'b0;
  endtask

  task automatic pulse_reset(input string tag);
    resetN = 1'b0;
    #1;
    check_outs({tag, " in reset"}, 8'h00, 32'd0);
    @(negedge clock);
    bus.coeffFinishedFlag = 1'b0;
    bus.dataFinishedFlag  = 1'b0;
    resetN = 1'b1;
    @(negedge clock);
  endtask

  initial begin
    bus.start             = 1'b0;
    bus.abort             = 1'b0;
    bus.coeffFinishedFlag = 1'b0;
    bus.dataFinishedFlag  = 1'b0;

    repeat (2) @(negedge clock);
    check_outs("reset held", 8'h00, 32'd0);
    resetN = 1'b1;
    @(negedge clock);
    check_outs("idle after reset", 8'h00, 32'd0);

    // Nominal pass; a start pulse mid-stream must be ignored.
    run_nominal("nominal", 20);

    // abort together with start in IDLE keeps the block idle.
    bus.start = 1'b1;
    bus.abort = 1'b1;
    @(negedge clock);
    bus.start = 1'b0;
    bus.abort = 1'b0;
    check_outs("abort+start", 8'h00, 32'd0);
    @(negedge clock);
    check_outs("abort+start later", 8'h00, 32'd0);

    // Coefficient flag never arrives: error five cycles after the last coefficient.
    launch();
    for (int k = 1; k <= 18; k++) begin
      bus.start = (k == 16);
      bus.abort = (k == 17);
      if (k <= 10)      check_outs($sformatf("ctimeout k=%0d", k), nom_vec(k), 32'd0);
      else if (k <= 14) check_outs($sformatf("ctimeout k=%0d", k), 8'b1000_0100, 32'd0);
      else              check_outs($sformatf("ctimeout k=%0d", k), 8'b0000_0001, 32'd0);
      @(negedge clock);
    end
    bus.start = 1'b0;
    bus.abort = 1'b0;
    pulse_reset("after ctimeout");
    check_outs("idle after ctimeout reset", 8'h00, 32'd0);

    // Data flag pulses early at dataIndex=10.
    launch();
    for (int k = 1; k <= 30; k++) begin
      bus.coeffFinishedFlag = (k >= 11);
      bus.dataFinishedFlag  = (k == 24);
      if (k <= 24) check_outs($sformatf("dearly k=%0d", k), nom_vec(k), nom_idx(k));
      else         check_outs($sformatf("dearly k=%0d", k), 8'b0000_0001, 32'd0);
      @(negedge clock);
    end
    pulse_reset("after dearly");

    // Abort at dataIndex=5, then a fresh pass completes.
    launch();
    for (int k = 1; k <= 19; k++) begin
      bus.coeffFinishedFlag = (k >= 11);
      check_outs($sformatf("abort k=%0d", k), nom_vec(k), nom_idx(k));
      bus.abort = (k == 19);
      @(negedge clock);
    end
    bus.abort             = 1'b0;
    bus.coeffFinishedFlag = 1'b0;
    check_outs("abort next", 8'h00, 32'd0);
    @(negedge clock);
    check_outs("abort idle", 8'h00, 32'd0);
    run_nominal("post-abort", 0);

    // Start while the coefficient reader is already exhausted.
    bus.coeffFinishedFlag = 1'b1;
    launch();
    check_outs("exhausted", 8'b0000_0001, 32'd0);
    @(negedge clock);
    check_outs("exhausted later", 8'b0000_0001, 32'd0);
    pulse_reset("after exhausted");

    // Asynchronous reset in the middle of LOAD_COEFF, then a full pass.
    launch();
    for (int k = 1; k <= 5; k++) begin
      check_outs($sformatf("midrst k=%0d", k), nom_vec(k), 32'd0);
      if (k < 5) @(negedge clock);
    end
    #1 resetN = 1'b0;
    #1;
    check_outs("midrst async", 8'h00, 32'd0);
    @(negedge clock);
    resetN = 1'b1;
    @(negedge clock);
    check_outs("midrst released", 8'h00, 32'd0);
    run_nominal("post-reset", 0);

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end
endmodule
